// File: rtl/count_snapshot_fifo.sv
// -----------------------------------------------------------------------------
// count_snapshot_fifo
//
// Captures {cc, count} snapshots from an upstream counter stage on each rising
// edge of trig and queues them in a small first-word fall-through FIFO. When
// the FIFO is full and nothing is popped in the same cycle, the capture is
// dropped. A sticky overflow flag and a saturating drop counter record drops.
//
// Parameters
//   DEPTH      number of entries (power of two, 2..16)
//   CW         width of the count input
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   count      free-running count value to snapshot
//   cc         2-bit status captured alongside count
//   trig       level capture request; only its rising edge captures
//   out_ready  downstream ready; a pop happens when out_valid & out_ready
//   clr_ovf    one-cycle pulse clearing overflow and drop_cnt
//   out_valid  head entry present (level != 0)
//   out_data   head entry {cc, count}, combinational from storage
//   level      number of stored entries
//   overflow   sticky: at least one capture was dropped
//   drop_cnt   saturating count of dropped captures
// -----------------------------------------------------------------------------
module count_snapshot_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CW-1:0]            count,
  input  logic [1:0]               cc,
  input  logic                     trig,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic [CW+1:0]            out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              LW         = AW + 1;
  localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);

  logic [CW+1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic           r_trig_q;
  logic           r_overflow;
  logic [7:0]     r_drop_cnt;

  logic           w_capture;
  logic           w_pop;
  logic           w_full;
  logic           w_write;
  logic           w_drop;

  assign w_capture = trig & ~r_trig_q;
  assign w_pop     = out_valid & out_ready;
  assign w_full    = (r_level == FULL_LEVEL);
  // When full, a simultaneous pop frees the head slot this very edge; since
  // wr_ptr == rd_ptr when full, the new entry lands in the slot being read
  // out, which becomes the tail once rd_ptr advances.
  assign w_write   = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  assign out_valid = (r_level != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

  // NOTE: storage has no reset; level gating out_valid is what hides stale
  // entries, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_write && !rst) begin
      r_mem[r_wr_ptr] <= {cc, count};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_trig_q   <= 1'b1;  // trig held high through reset must not capture
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_trig_q <= trig;

      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);

      unique case ({w_write, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      // A drop in the same cycle as a clear wins over the clear.
      if (clr_ovf) begin
        r_overflow <= w_drop;
        r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// -----------------------------------------------------------------------------
// tb_count_snapshot_fifo
//
// Drives directed scenarios and randomized traffic into count_snapshot_fifo and
// compares every cycle against a queue-based reference model of the FIFO,
// its overflow flag and its saturating drop counter.
// -----------------------------------------------------------------------------
module tb_count_snapshot_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [CW-1:0]     count;
  logic [1:0]        cc;
  logic              trig;
  logic              out_ready;
  logic              clr_ovf;
  logic              out_valid;
  logic [CW+1:0]     out_data;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [7:0]        drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [CW+1:0] m_q[$];
  logic          m_trig_q = 1'b1;
  logic          m_ovf    = 1'b0;
  int            m_drop   = 0;

  always #5 clk = ~clk;

  count_snapshot_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .cc        (cc),
    .trig      (trig),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs currently driven,
  // let the DUT take the edge, then compare all outputs 1 time unit later.
  task automatic step();
    bit cap, pop, full, dropped;
    if (rst) begin
      m_q.delete();
      m_trig_q = 1'b1;
      m_ovf    = 1'b0;
      m_drop   = 0;
    end else begin
      cap     = trig && !m_trig_q;
      pop     = (m_q.size() != 0) && out_ready;
      full    = (m_q.size() == DEPTH);
      dropped = cap && full && !pop;
      if (pop) void'(m_q.pop_front());
      if (cap && !dropped) m_q.push_back({cc, count});
      if (clr_ovf) begin
        m_ovf  = dropped;
        m_drop = dropped ? 1 : 0;
      end else if (dropped) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
      m_trig_q = trig;
    end
    @(posedge clk);
    #1;
    check("level", level, m_q.size());
    check("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One low cycle then one high cycle on trig: a single capture request.
  task automatic trig_edge(input logic [CW-1:0] c, input logic [1:0] s, input logic rdy);
    trig = 1'b0; out_ready = 1'b0;
    step();
    trig = 1'b1; count = c; cc = s; out_ready = rdy;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; trig = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; trig = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;
    count = '0; cc = '0;

    // Trig held high through reset (cycles 0-2) must never capture.
    steps(3);
    rst = 1'b0;
    steps(5);
    check("trig_hold_level", level, 0);
    trig = 1'b0; step();
    trig = 1'b1; count = 16'h0abc; cc = 2'b11; step();
    check("trig_rerise_level", level, 1);

    // Single capture: visible exactly one cycle after the rising edge.
    do_reset();
    trig = 1'b0; steps(9);
    trig = 1'b1; count = 16'h0012; cc = 2'b01;
    step();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 18'h10012);
    check("single_level", level, 1);
    trig = 1'b0;

    // Fill and drop: six edges into a four-entry FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) trig_edge(CW'(100 + i), 2'b10, 1'b0);
    check("fd_level", level, 4);
    check("fd_ovf", overflow, 1);
    check("fd_drop", drop_cnt, 2);
    trig = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fd_drain_data", out_data, {2'b10, 16'(100 + i)});
      step();
    end
    check("fd_empty", out_valid, 0);
    out_ready = 1'b0;

    // Full plus simultaneous capture and pop.
    do_reset();
    for (int i = 0; i < 4; i++) trig_edge(CW'(200 + i), 2'b00, 1'b0);
    trig_edge(16'd204, 2'b01, 1'b1);
    check("fp_level", level, 4);
    check("fp_ovf", overflow, 0);
    check("fp_head", out_data, {2'b00, 16'd201});
    trig = 1'b0; out_ready = 1'b1;
    steps(3);
    check("fp_last", out_data, {2'b01, 16'd204});
    step();
    out_ready = 1'b0;

    // Saturation and clear coincident with a drop.
    do_reset();
    for (int i = 0; i < 4; i++) trig_edge(CW'(i), 2'b00, 1'b0);
    for (int i = 0; i < 300; i++) trig_edge(CW'(i), 2'b11, 1'b0);
    check("sat_drop", drop_cnt, 255);
    trig = 1'b0; step();
    trig = 1'b1; clr_ovf = 1'b1; step();
    clr_ovf = 1'b0;
    check("clr_drop_ovf", overflow, 1);
    check("clr_drop_cnt", drop_cnt, 1);
    trig = 1'b0; clr_ovf = 1'b1; step();
    clr_ovf = 1'b0;
    check("clr_only_ovf", overflow, 0);
    check("clr_only_level", level, 4);

    // Reset mid-stream with a drop recorded.
    do_reset();
    for (int i = 0; i < 5; i++) trig_edge(CW'(300 + i), 2'b01, 1'b0);
    out_ready = 1'b1; trig = 1'b0; step(); out_ready = 1'b0;
    check("mid_level", level, 3);
    rst = 1'b1; trig = 1'b1; out_ready = 1'b1; clr_ovf = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_drop", drop_cnt, 0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clr_ovf   = ($urandom_range(0, 29) == 0);
      trig      = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) == 0);
      count     = CW'($urandom);
      cc        = 2'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_snapshot_fifo.md
COUNT_SNAPSHOT_FIFO -- requirements
Module: count_snapshot_fifo

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clk is the clock; rst is synchronous and active-high.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of FIFO entries; the legal value is a power of two from 2 to 16.
REQ-003 Parameter CW, default 16, SHALL set the width of the count input.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 count  input  CW  SHALL be the free-running count value from the upstream counter stage.
REQ-007 cc  input  2  SHALL be the 2-bit status from the upstream counter stage.
REQ-008 trig  input  1  SHALL be the level capture request; only its rising edge captures.
REQ-009 out_ready  input  1  SHALL be the downstream consumer's ready signal.
REQ-010 clr_ovf  input  1  SHALL be a one-cycle pulse that clears overflow and drop_cnt.
REQ-011 out_valid  output  1  SHALL indicate that the head entry is present.
REQ-012 out_data  output  CW+2  SHALL carry the head entry as {cc, count}.
REQ-013 level  output  log2(DEPTH)+1  SHALL report the current number of stored entries.
REQ-014 overflow  output  1  SHALL be a sticky flag indicating that at least one capture was dropped.
REQ-015 drop_cnt  output  8  SHALL be a saturating count of dropped captures.

Function
REQ-016 An internal register trig_q SHALL hold trig from the previous cycle.
REQ-017 A capture event SHALL occur in a cycle where trig=1 and trig_q=0.
REQ-018 A capture event SHALL sample {cc, count} in that same cycle.
REQ-019 A pop SHALL occur in a cycle where out_valid=1 and out_ready=1.
REQ-020 out_valid SHALL be 1 exactly when level is non-zero.
REQ-021 out_data SHALL be driven combinationally from the head entry (first-word fall-through).
REQ-022 out_data SHALL be don't-care when out_valid=0.
REQ-023 A capture accepted in cycle N SHALL first appear on out_valid/out_data in cycle N+1; there SHALL be no same-cycle bypass, even when the FIFO is empty.
REQ-024 Entries SHALL be delivered in strict capture order, with no duplication or loss of accepted entries.
REQ-025 A capture with level < DEPTH SHALL be written and SHALL increment level.
REQ-026 A pop without a capture SHALL decrement level.
REQ-027 A simultaneous capture and pop SHALL write and read in the same cycle and SHALL leave level unchanged, including when level = DEPTH.
REQ-028 A capture with level = DEPTH and no pop in the same cycle SHALL be dropped: no write occurs, overflow is set to 1, and drop_cnt increments.
REQ-029 drop_cnt SHALL saturate at 255 and SHALL never wrap.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 level SHALL never exceed DEPTH and SHALL never go below 0.
REQ-032 A pop attempted when empty is impossible, because out_valid=0 when empty.
REQ-033 When clr_ovf=1, overflow SHALL be cleared and drop_cnt SHALL be set to 0.
REQ-034 When clr_ovf=1 and a drop occur in the same cycle, the next state SHALL be overflow=1 and drop_cnt=1.
REQ-035 clr_ovf SHALL NOT affect FIFO contents, pointers or level.
REQ-036 Storage SHALL be flip-flop based with no memory macro; overflow and drop_cnt SHALL be registered outputs.

Reset
REQ-037 While rst=1 at a clock edge, level, both pointers, overflow and drop_cnt SHALL become 0, and out_valid SHALL be 0 in the following cycle.
REQ-038 While rst=1 at a clock edge, trig_q SHALL become 1, so that trig held high through reset produces no capture.
REQ-039 rst SHALL take priority over capture, pop and clr_ovf in the same cycle.
REQ-040 Reset mid-operation SHALL discard all stored entries, and no stale entry SHALL be presented after reset.
REQ-041 Storage contents SHALL NOT require reset.

Verification
REQ-042 Single capture: count=16'h0012, cc=2'b01, rising edge of trig at cycle 10, out_ready=0 -> in cycle 11, out_valid=1, out_data=18'h10012, level=1.
REQ-043 Fill and drop: DEPTH=4, 6 trig edges, out_ready=0 -> level=4, overflow=1, drop_cnt=2; drain yields the first 4 captures in order.
REQ-044 Full plus simultaneous capture and pop: level=4, trig edge with out_ready=1 -> level stays 4, overflow stays 0, the head advances, and the new entry is the last out.
REQ-045 Saturation and clear: 300 drops -> drop_cnt=255; then clr_ovf coincident with a drop -> overflow=1, drop_cnt=1.
REQ-046 Trig held high: trig=1 throughout, rst asserted for cycles 0-2 -> no capture occurs, and level=0 until trig falls and rises again.
REQ-047 Reset mid-stream: level=3, rst pulsed for 1 cycle -> next cycle level=0, out_valid=0, overflow=0, drop_cnt=0.
